// File: rtl/id_ex_stage.sv
// Decode->execute pipeline register with operand forwarding, load-use stall,
// writeback snooping and a valid/ready handshake on both sides.
package id_ex_pkg;
   typedef enum logic [3:0] {
      alu_add  = 4'd0,
      alu_and  = 4'd1,
      alu_or   = 4'd2,
      alu_xor  = 4'd3,
      alu_sll  = 4'd4,
      alu_srl  = 4'd5,
      alu_sra  = 4'd6,
      alu_slt  = 4'd7,
      alu_sltu = 4'd8
   } alu_op_t;
endpackage

module id_ex_stage
   import id_ex_pkg::*;
#(
   parameter int unsigned Width    = 32,
   parameter int unsigned RegAddrW = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [Width-1:0]    in_pc,
   input  alu_op_t             in_op,
   input  logic                in_invert_b,
   input  logic [RegAddrW-1:0] in_rs1,
   input  logic [RegAddrW-1:0] in_rs2,
   input  logic                in_rs1_used,
   input  logic                in_rs2_used,
   input  logic [Width-1:0]    in_rs1_val,
   input  logic [Width-1:0]    in_rs2_val,
   input  logic [Width-1:0]    in_imm,
   input  logic                in_use_pc,
   input  logic                in_use_imm,
   input  logic [RegAddrW-1:0] in_rd,
   input  logic                in_wb_en,
   input  logic                in_is_load,
   input  logic                exm_wb_en,
   input  logic [RegAddrW-1:0] exm_rd,
   input  logic [Width-1:0]    exm_data,
   input  logic                exm_data_ok,
   input  logic                wb_en,
   input  logic [RegAddrW-1:0] wb_rd,
   input  logic [Width-1:0]    wb_data,
   output logic                out_valid,
   input  logic                out_ready,
   output alu_op_t             out_op,
   output logic [Width-1:0]    out_a,
   output logic [Width-1:0]    out_b,
   output logic                out_invert_b,
   output logic [Width-1:0]    out_store_data,
   output logic [Width-1:0]    out_pc,
   output logic [RegAddrW-1:0] out_rd,
   output logic                out_wb_en,
   output logic                out_is_load
);

   logic                valid_q, valid_d;
   logic [Width-1:0]    pc_q, pc_d;
   alu_op_t             op_q, op_d;
   logic                invert_b_q, invert_b_d;
   logic [RegAddrW-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
   logic                rs1_used_q, rs1_used_d, rs2_used_q, rs2_used_d;
   logic [Width-1:0]    rs1_val_q, rs1_val_d, rs2_val_q, rs2_val_d;
   logic [Width-1:0]    imm_q, imm_d;
   logic                use_pc_q, use_pc_d, use_imm_q, use_imm_d;
   logic [RegAddrW-1:0] rd_q, rd_d;
   logic                wb_en_q, wb_en_d;
   logic                is_load_q, is_load_d;

   logic             hazard_c;
   logic             out_fire_c;
   logic             capture_c;
   logic [Width-1:0] fwd1_c, fwd2_c;

   // Writeback value for a register if it is being written this cycle.
   function automatic logic [Width-1:0] wb_pick(input logic [RegAddrW-1:0] rs,
                                                input logic [Width-1:0]    val);
      if (wb_en && (wb_rd != '0) && (wb_rd == rs)) return wb_data;
      return val;
   endfunction

   // EX/MEM beats writeback; x0 reads as zero regardless of what was captured.
   function automatic logic [Width-1:0] fwd(input logic [RegAddrW-1:0] rs,
                                            input logic [Width-1:0]    val);
      if (rs == '0) return '0;
      if (exm_wb_en && (exm_rd == rs)) return exm_data;
      return wb_pick(rs, val);
   endfunction

   always_comb begin
      hazard_c = valid_q && !exm_data_ok && exm_wb_en &&
                 ((rs1_used_q && (rs1_q != '0) && (exm_rd == rs1_q)) ||
                  (rs2_used_q && (rs2_q != '0) && (exm_rd == rs2_q)));
      out_valid  = valid_q && !hazard_c;
      out_fire_c = out_valid && out_ready;
      in_ready   = !flush && (!valid_q || out_fire_c);
      capture_c  = in_valid && in_ready;
      fwd1_c     = fwd(rs1_q, rs1_val_q);
      fwd2_c     = fwd(rs2_q, rs2_val_q);
   end

   assign out_op         = op_q;
   assign out_a          = use_pc_q  ? pc_q  : fwd1_c;
   assign out_b          = use_imm_q ? imm_q : fwd2_c;
   assign out_invert_b   = invert_b_q;
   assign out_store_data = fwd2_c;
   assign out_pc         = pc_q;
   assign out_rd         = rd_q;
   assign out_wb_en      = wb_en_q;
   assign out_is_load    = is_load_q;

   // Next-state: flush dominates, then capture, then drain on fire; held operands snoop writeback.
   always_comb begin
      valid_d    = valid_q;
      pc_d       = pc_q;
      op_d       = op_q;
      invert_b_d = invert_b_q;
      rs1_d      = rs1_q;
      rs2_d      = rs2_q;
      rs1_used_d = rs1_used_q;
      rs2_used_d = rs2_used_q;
      rs1_val_d  = wb_pick(rs1_q, rs1_val_q);
      rs2_val_d  = wb_pick(rs2_q, rs2_val_q);
      imm_d      = imm_q;
      use_pc_d   = use_pc_q;
      use_imm_d  = use_imm_q;
      rd_d       = rd_q;
      wb_en_d    = wb_en_q;
      is_load_d  = is_load_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (capture_c) begin
         valid_d    = 1'b1;
         pc_d       = in_pc;
         op_d       = in_op;
         invert_b_d = in_invert_b;
         rs1_d      = in_rs1;
         rs2_d      = in_rs2;
         rs1_used_d = in_rs1_used;
         rs2_used_d = in_rs2_used;
         rs1_val_d  = wb_pick(in_rs1, in_rs1_val);
         rs2_val_d  = wb_pick(in_rs2, in_rs2_val);
         imm_d      = in_imm;
         use_pc_d   = in_use_pc;
         use_imm_d  = in_use_imm;
         rd_d       = in_rd;
         wb_en_d    = in_wb_en;
         is_load_d  = in_is_load;
      end else if (out_fire_c) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q    <= 1'b0;
         pc_q       <= '0;
         op_q       <= alu_add;
         invert_b_q <= 1'b0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rs1_used_q <= 1'b0;
         rs2_used_q <= 1'b0;
         rs1_val_q  <= '0;
         rs2_val_q  <= '0;
         imm_q      <= '0;
         use_pc_q   <= 1'b0;
         use_imm_q  <= 1'b0;
         rd_q       <= '0;
         wb_en_q    <= 1'b0;
         is_load_q  <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         pc_q       <= pc_d;
         op_q       <= op_d;
         invert_b_q <= invert_b_d;
         rs1_q      <= rs1_d;
         rs2_q      <= rs2_d;
         rs1_used_q <= rs1_used_d;
         rs2_used_q <= rs2_used_d;
         rs1_val_q  <= rs1_val_d;
         rs2_val_q  <= rs2_val_d;
         imm_q      <= imm_d;
         use_pc_q   <= use_pc_d;
         use_imm_q  <= use_imm_d;
         rd_q       <= rd_d;
         wb_en_q    <= wb_en_d;
         is_load_q  <= is_load_d;
      end
   end

endmodule
